ps2_rx: RTL and testbench

PS2_RX -- requirements
Module: ps2_rx

---
 rtl/ps2_rx.sv | 220 ++++++++++++++++++++++
 tb/tb_ps2_rx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx.sv
// ============================================================================
// Module   : ps2_rx
// Purpose  : PS/2 keyboard frame receiver.
//            - Synchronizes the raw PS/2 clock and data lines.
//            - Filters the clock line.
//            - Decodes 11-bit frames (start, 8 data LSB first, odd parity, stop).
//            - Presents each good scan code through a one-entry holding register.
// Options  : define PS2_RX_TIMEOUT_EN to abort a partial frame after
//            TIMEOUT_CYCLES clk cycles with no filtered falling edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kbdClk,
  input  logic       kbdDatain,
  output logic [7:0] dataOut,
  output logic       dataValid,
  input  logic       dataReady,
  output logic       frameErr,
  output logic       overflow
);

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  logic           kclk_s1_q, kclk_s2_q, kdat_s1_q, kdat_s2_q;
  logic           filt_q, filt_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic           fall;

  state_t         state_q, state_d;
  logic [2:0]     bitcnt_q, bitcnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic           good, bad, timeout;

  logic [7:0]     dout_q, dout_d;
  logic           valid_q, valid_d;
  logic           ferr_q, ferr_d;
  logic           ovf_q, ovf_d;
  logic           pop, load;

  // Two-flop synchronizers; idle bus level is high, so reset to 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kclk_s1_q <= 1'b1;
      kclk_s2_q <= 1'b1;
      kdat_s1_q <= 1'b1;
      kdat_s2_q <= 1'b1;
    end else begin
      kclk_s1_q <= kbdClk;
      kclk_s2_q <= kclk_s1_q;
      kdat_s1_q <= kbdDatain;
      kdat_s2_q <= kdat_s1_q;
    end
  end

  // Filter: the level flips after FILTER_LEN consecutive samples that differ from it.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (kclk_s2_q != filt_q) begin
      if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
        filt_d = kclk_s2_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  // Filter state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  // The frame logic acts in the same cycle that the filtered clock falls.
  assign fall = filt_q & ~filt_d;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCW-1:0] to_q, to_d;

  // Count idle time inside a frame; an edge or the IDLE state restarts the count.
  always_comb begin
    to_d    = to_q;
    timeout = 1'b0;
    if (state_q == IDLE || fall) begin
      to_d = '0;
    end else if (to_q == TCW'(TIMEOUT_CYCLES - 1)) begin
      timeout = 1'b1;
      to_d    = '0;
    end else begin
      to_d = to_q + 1'b1;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end
`else
  // No timeout: a partial frame waits for edges indefinitely.
  assign timeout = 1'b0;
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

  // Frame decoder: next state and the good/bad frame verdict.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    good     = 1'b0;
    bad      = 1'b0;
    if (timeout) begin
      state_d = IDLE;
    end else if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (!kdat_s2_q) begin
            state_d  = DATA;
            bitcnt_d = 3'd0;
          end
        end
        DATA: begin
          shift_d = {kdat_s2_q, shift_q[7:1]};
          if (bitcnt_q == 3'd7) begin
            state_d = PARITY;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end
        PARITY: begin
          par_d   = kdat_s2_q;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if ((^{shift_q, par_q}) && kdat_s2_q) begin
            good = 1'b1;
          end else begin
            bad = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Frame decoder state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
    end
  end

  // Holding register: a same-cycle pop makes room for a new code.
  always_comb begin
    pop     = valid_q & dataReady;
    load    = good & (~valid_q | pop);
    dout_d  = load ? shift_q : dout_q;
    valid_d = load | (valid_q & ~pop);
    ovf_d   = ovf_q | (good & valid_q & ~dataReady);
    ferr_d  = bad | timeout;
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign dataOut   = dout_q;
  assign dataValid = valid_q;
  assign frameErr  = ferr_q;
  assign overflow  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_rx.sv
// ============================================================================
// Module   : tb_ps2_rx
// Purpose  : Self-checking bench for ps2_rx.
//            - Drives directed and randomized PS/2 frames.
//            - Compares outputs against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ps2_rx;

  localparam int TO   = 2000;
  localparam int HALF = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       kbdClk = 1'b1;
  logic       kbdDatain = 1'b1;
  logic       dataReady = 1'b0;
  logic [7:0] dataOut;
  logic       dataValid;
  logic       frameErr;
  logic       overflow;

  ps2_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .kbdClk    (kbdClk),
    .kbdDatain (kbdDatain),
    .dataOut   (dataOut),
    .dataValid (dataValid),
    .dataReady (dataReady),
    .frameErr  (frameErr),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   err_seen = 0;
  int   low_cnt  = 0;
  int   rise_cyc = -1;
  logic prev_v   = 1'b0;
  int   stop_cyc = 0;

  // Reference model: the holding register contents and the expected error count.
  logic [7:0] m_data  = 8'h00;
  bit         m_valid = 1'b0;
  bit         m_ovf   = 1'b0;
  int         m_err   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: counts frameErr high cycles, dataValid low cycles and valid rise time.
  always @(negedge clk) begin
    if (frameErr) err_seen++;
    if (!dataValid) low_cnt++;
    if (dataValid && !prev_v) rise_cyc = cyc;
    prev_v = dataValid;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    @(negedge clk);
    check({tag, ".dataOut"},   {24'd0, dataOut},   {24'd0, m_data});
    check({tag, ".dataValid"}, {31'd0, dataValid}, {31'd0, m_valid});
    check({tag, ".overflow"},  {31'd0, overflow},  {31'd0, m_ovf});
    check({tag, ".frameErr"},  err_seen,           m_err);
  endtask

  function automatic logic [10:0] mk(input logic [7:0] d, input bit p, input bit s);
    return {s, p, d, 1'b0};
  endfunction

  // One PS/2 bit: data set while the clock is high, then a low phase.
  // pop_at > 1 raises dataReady for the single clk edge that comes pop_at
  // edges after the falling kbdClk.
  task automatic bit_out(input bit b, input int pop_at);
    @(posedge clk); #1 kbdDatain = b;
    repeat (HALF) @(posedge clk);
    #1 kbdClk = 1'b0;
    stop_cyc = cyc;
    for (int i = 1; i <= HALF; i++) begin
      @(posedge clk); #1;
      dataReady = (i == pop_at - 1);
    end
    kbdClk = 1'b1;
  endtask

  task automatic send(input logic [10:0] f, input int from, input int to, input int pop_at);
    for (int i = from; i <= to; i++) bit_out(f[i], (i == 10) ? pop_at : 0);
    kbdDatain = 1'b1;
    repeat (HALF + 10) @(posedge clk);
  endtask

  task automatic model_frame(input logic [7:0] d, input bit p, input bit s, input bit popped);
    bit good;
    good = (^{d, p}) && s;
    if (!good) begin
      m_err++;
      if (popped) m_valid = 1'b0;
    end else if (!m_valid || popped) begin
      m_data  = d;
      m_valid = 1'b1;
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic frame(input logic [7:0] d, input bit p, input bit s, input int pop_at);
    bit popped;
    popped = (pop_at > 0) && m_valid;
    send(mk(d, p, s), 0, 10, pop_at);
    model_frame(d, p, s, popped);
  endtask

  task automatic pop();
    @(posedge clk); #1 dataReady = 1'b1;
    @(posedge clk); #1 dataReady = 1'b0;
    m_valid = 1'b0;
  endtask

  int L;
  int base;
  logic [7:0] rd;
  bit rp, rs;

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    check_state("reset");
    #1 rst = 1'b1;
    repeat (20) @(posedge clk);

    // Parity error on 0x1C: one frameErr pulse, nothing loaded.
    frame(8'h1C, 1'b1, 1'b1, 0);
    check_state("bad_parity");

    // Good 0x1C; also measure stop-edge to dataValid latency.
    frame(8'h1C, 1'b0, 1'b1, 0);
    check_state("good_1C");
    L = rise_cyc - stop_cyc;
    check("latency_range", {31'd0, (L >= 3 && L <= 40)}, 32'd1);

    // Pop in the very cycle 0x29 loads over pending 0x1C: valid never drops.
    base = low_cnt;
    frame(8'h29, 1'b0, 1'b1, L);
    check_state("same_cycle_pop");
    check("same_cycle_pop.valid_gap", low_cnt - base, 32'd0);

    // Overflow: 0x1C held, 0xF0 dropped.
    pop();
    check_state("pop_29");
    frame(8'h1C, 1'b0, 1'b1, 0);
    frame(8'hF0, 1'b1, 1'b1, 0);
    check_state("overflow");
    pop();
    check_state("overflow_after_pop");

    // Bad stop bit, then dataReady while empty.
    frame(8'h55, ~^8'h55, 1'b0, 0);
    check_state("bad_stop");
    pop();
    check_state("ready_when_empty");

    // Randomized frames and pops.
    for (int k = 0; k < 10; k++) begin
      rd = 8'($urandom);
      rp = (^rd) ? 1'b0 : 1'b1;
      if ($urandom_range(3) == 0) rp = ~rp;
      rs = ($urandom_range(5) != 0);
      frame(rd, rp, rs, 0);
      check_state("rand_frame");
      if ($urandom_range(1) == 1) begin
        pop();
        check_state("rand_pop");
      end
    end

    // Reset after the 4th data bit discards the partial frame.
    send(mk(8'h1C, 1'b0, 1'b1), 0, 4, 0);
    @(posedge clk); #1 rst = 1'b0;
    m_data = 8'h00; m_valid = 1'b0; m_ovf = 1'b0;
    repeat (3) @(posedge clk);
    check_state("mid_reset");
    #1 rst = 1'b1;
    repeat (20) @(posedge clk);
    frame(8'h1C, 1'b0, 1'b1, 0);
    check_state("after_reset_1C");

    pop();
`ifdef PS2_RX_TIMEOUT_EN
    // Partial frame abandoned: one timeout frameErr, then a clean frame.
    send(mk(8'h29, 1'b0, 1'b1), 0, 5, 0);
    repeat (TO + 50) @(posedge clk);
    m_err++;
    check_state("timeout");
    frame(8'h29, 1'b0, 1'b1, 0);
    check_state("after_timeout_29");
`else
    // Partial frame waits indefinitely, then completes.
    send(mk(8'h29, 1'b0, 1'b1), 0, 5, 0);
    repeat (TO + 50) @(posedge clk);
    check_state("long_pause");
    send(mk(8'h29, 1'b0, 1'b1), 6, 10, 0);
    model_frame(8'h29, 1'b0, 1'b1, 1'b0);
    check_state("resumed_29");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
